// File: rtl/sram_spi_master_if.sv
// CPU-side request/response bus for the serial-SRAM master.
// Latency: none; plain wires bundled with direction-checked modports.
// Backpressure: requester must watch busy; requests while busy are dropped.
interface sram_spi_master_if #(
    parameter int ADDR_W = 24
);
    logic              ce;
    logic              memwrite;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       datain;
    logic [31:0]       dataout;
    logic              busy;
    logic              valid;

    // Requester side (CPU memory/fetch stage)
    modport master (
        output ce, memwrite, funct3, addr, datain,
        input  dataout, busy, valid
    );

    // Responder side (the SPI SRAM master)
    modport slave (
        input  ce, memwrite, funct3, addr, datain,
        output dataout, busy, valid
    );
endinterface

// File: rtl/sram_spi_master.sv
// Serial-SRAM master: one byte/half/word load or store as a single SPI mode-0 sequential transfer.
// Latency: valid at accept + 1 + 2*SCLK_HALF*(8+ADDR_W+8*bytes) cycles; busy high in between.
// Backpressure: nothing is queued; ce is ignored while busy and during the valid cycle.
module sram_spi_master #(
    parameter int SCLK_HALF = 1,
    parameter int ADDR_W    = 24
) (
    input  logic             clk,
    input  logic             reset,
    sram_spi_master_if.slave bus,
    output logic             si,
    input  logic             so,
    output logic             sclk,
    output logic             sram_ce
);
    // Shift register holds command, address and up to four write bytes.
    localparam int SR_W  = 8 + ADDR_W + 32;
    localparam int BIT_W = $clog2(SR_W + 1);
    localparam int HC_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    localparam logic [HC_W-1:0]  HALF_LAST  = HC_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] DATA_START = BIT_W'(8 + ADDR_W);
    localparam logic [7:0]       CMD_READ   = 8'h03;
    localparam logic [7:0]       CMD_WRITE  = 8'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [SR_W-1:0]    sr_q,       sr_d;
    logic [31:0]        rx_q,       rx_d;
    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [BIT_W-1:0]   last_bit_q, last_bit_d;
    logic [HC_W-1:0]    half_cnt_q, half_cnt_d;
    logic               read_q,     read_d;
    logic               zext_q,     zext_d;
    logic [1:0]         size_q,     size_d;
    logic [31:0]        dataout_q,  dataout_d;
    logic               busy_q,     busy_d;
    logic               valid_q,    valid_d;
    logic               sclk_q,     sclk_d;
    logic               sram_ce_q,  sram_ce_d;

    logic [BIT_W-1:0]   req_bits;
    logic [7:0]         req_cmd;
    logic [4:0]         data_bit;
    logic [4:0]         rx_idx;
    logic [31:0]        load_ext;

    // Request decode: data bit count and command byte for the incoming access.
    always_comb begin
        req_cmd = bus.memwrite ? CMD_WRITE : CMD_READ;
        case (bus.funct3[1:0])
            2'b00:   req_bits = BIT_W'(8);
            2'b01:   req_bits = BIT_W'(16);
            default: req_bits = BIT_W'(32);
        endcase
    end

    // Received bits land byte-by-byte little-endian, MSB-first inside each byte.
    always_comb begin
        data_bit = 5'(bit_cnt_q - DATA_START);
        rx_idx   = {data_bit[4:3], ~data_bit[2:0]};
        case (size_q)
            2'b00:   load_ext = {{24{~zext_q & rx_q[7]}},  rx_q[7:0]};
            2'b01:   load_ext = {{16{~zext_q & rx_q[15]}}, rx_q[15:0]};
            default: load_ext = rx_q;
        endcase
    end

    // Next-state logic for the transfer sequencer and all registered outputs.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        half_cnt_d = half_cnt_q;
        read_d     = read_q;
        zext_d     = zext_q;
        size_d     = size_q;
        dataout_d  = dataout_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        sclk_d     = sclk_q;
        sram_ce_d  = sram_ce_q;

        case (state_q)
            IDLE: begin
                if (bus.ce) begin
                    state_d    = SHIFT;
                    // Write bytes go out lowest byte first, so reverse byte order here.
                    sr_d       = {req_cmd, bus.addr,
                                  bus.datain[7:0], bus.datain[15:8],
                                  bus.datain[23:16], bus.datain[31:24]};
                    rx_d       = '0;
                    bit_cnt_d  = '0;
                    last_bit_d = DATA_START + req_bits - BIT_W'(1);
                    half_cnt_d = '0;
                    read_d     = ~bus.memwrite;
                    zext_d     = bus.funct3[2];
                    size_d     = bus.funct3[1:0];
                    busy_d     = 1'b1;
                    sclk_d     = 1'b0;
                    sram_ce_d  = 1'b0;
                end
            end

            SHIFT: begin
                if (half_cnt_q != HALF_LAST) begin
                    half_cnt_d = half_cnt_q + HC_W'(1);
                end else begin
                    half_cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: sample MISO during the data phase of a load.
                        sclk_d = 1'b1;
                        if (read_q && (bit_cnt_q >= DATA_START)) begin
                            rx_d[rx_idx] = so;
                        end
                    end else begin
                        // Falling edge: either finish or present the next MOSI bit.
                        sclk_d = 1'b0;
                        if (bit_cnt_q == last_bit_q) begin
                            state_d   = DONE;
                            sr_d      = '0;
                            sram_ce_d = 1'b1;
                            busy_d    = 1'b0;
                            valid_d   = 1'b1;
                            if (read_q) begin
                                dataout_d = load_ext;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            sr_d      = {sr_q[SR_W-2:0], 1'b0};
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and deselects the SRAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= '0;
            half_cnt_q <= '0;
            read_q     <= 1'b0;
            zext_q     <= 1'b0;
            size_q     <= 2'b00;
            dataout_q  <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            sclk_q     <= 1'b0;
            sram_ce_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            half_cnt_q <= half_cnt_d;
            read_q     <= read_d;
            zext_q     <= zext_d;
            size_q     <= size_d;
            dataout_q  <= dataout_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            sclk_q     <= sclk_d;
            sram_ce_q  <= sram_ce_d;
        end
    end

    assign si          = sr_q[SR_W-1];
    assign sclk        = sclk_q;
    assign sram_ce     = sram_ce_q;
    assign bus.dataout = dataout_q;
    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;
endmodule

// File: tb/tb_sram_spi_master.sv
// Bench for sram_spi_master: behavioural 23LC1024 model, byte-array reference, protocol monitor.
// Latency: checks exact valid cycle against 1 + 2*SCLK_HALF*(8+ADDR_W+8N).
// Backpressure: exercises ce while busy and in the valid cycle.
module tb_sram_spi_master;
    localparam int ADDR_W = 24;
    localparam int MEM_SZ = 131072;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    sram_spi_master_if #(.ADDR_W(ADDR_W)) bus  ();
    sram_spi_master_if #(.ADDR_W(ADDR_W)) bus2 ();

    logic si, sclk, sram_ce;
    logic so = 1'b0;
    logic si2, sclk2, sram_ce2;
    logic so2;
    assign so2 = 1'b0;

    sram_spi_master #(.SCLK_HALF(1), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .si(si), .so(so), .sclk(sclk), .sram_ce(sram_ce)
    );

    sram_spi_master #(.SCLK_HALF(2), .ADDR_W(ADDR_W)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .si(si2), .so(so2), .sclk(sclk2), .sram_ce(sram_ce2)
    );

    // ---------------- behavioural serial SRAM (sequential mode) ----------------
    logic [7:0]  sram_mem [MEM_SZ];
    logic [7:0]  ref_mem  [MEM_SZ];
    int          m_bits = 0;
    int          m_addr = 0;
    int          m_k    = 0;
    logic [31:0] m_sh   = '0;
    logic [7:0]  m_cmd  = '0;
    int          ce_falls = 0;
    logic        si_log [$];

    always @(negedge sram_ce) begin
        m_bits   = 0;
        ce_falls = ce_falls + 1;
    end

    always @(posedge sclk) begin
        if (sram_ce === 1'b0) begin
            si_log.push_back(si);
            m_sh   = {m_sh[30:0], si};
            m_bits = m_bits + 1;
            if (m_bits == 32) begin
                m_cmd  = m_sh[31:24];
                m_addr = int'(m_sh[16:0]);
            end else if (m_bits > 32 && (m_bits % 8) == 0 && m_cmd == 8'h02) begin
                sram_mem[(m_addr + (m_bits - 40) / 8) % MEM_SZ] = m_sh[7:0];
            end
        end
    end

    always @(negedge sclk) begin
        if (sram_ce === 1'b0 && m_bits >= 32 && m_cmd == 8'h03) begin
            m_k = m_bits - 32;
            so  = sram_mem[(m_addr + m_k / 8) % MEM_SZ][7 - (m_k % 8)];
        end
    end

    // ---------------- protocol monitor (both instances) ----------------
    int   proto_err = 0;
    logic sclk_p = 1'b0, si_p = 1'b0, sclk2_p = 1'b0, si2_p = 1'b0;
    int   rise2 [$];
    logic si2_log [$];

    always @(negedge clk) begin
        if (sclk === 1'b1 && sram_ce !== 1'b0) proto_err = proto_err + 1;
        if (sclk2 === 1'b1 && sram_ce2 !== 1'b0) proto_err = proto_err + 1;
        if (sclk === 1'b1 && sclk_p === 1'b0 && si !== si_p) proto_err = proto_err + 1;
        if (sclk2 === 1'b1 && sclk2_p === 1'b0) begin
            if (si2 !== si2_p) proto_err = proto_err + 1;
            rise2.push_back(cyc);
            si2_log.push_back(si2);
        end
        sclk_p  = sclk;
        si_p    = si;
        sclk2_p = sclk2;
        si2_p   = si2;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_dout = '0;

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int exp_lat(input int half, input logic [2:0] f3);
        return 1 + 2 * half * (8 + ADDR_W + 8 * nbytes(f3));
    endfunction

    function automatic logic [31:0] ref_load(input logic [23:0] a, input logic [2:0] f3);
        int          n;
        logic [31:0] v;
        n = nbytes(f3);
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[(int'(a) + i) % MEM_SZ]) << (8 * i));
        if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [23:0] a, input logic [2:0] f3, input logic [31:0] d);
        for (int i = 0; i < nbytes(f3); i++)
            ref_mem[(int'(a) + i) % MEM_SZ] = d[8*i +: 8];
    endtask

    // Expected MOSI stream, right-aligned: cmd, addr, then write bytes low byte first.
    function automatic logic [63:0] exp_stream(input logic mw, input logic [23:0] a,
                                               input logic [31:0] d, input int n);
        logic [63:0] s;
        s = {32'd0, (mw ? 8'h02 : 8'h03), a};
        if (mw)
            for (int i = 0; i < n; i++) s = (s << 8) | 64'(d[8*i +: 8]);
        return s;
    endfunction

    task automatic poke(input int a, input logic [7:0] v);
        sram_mem[a % MEM_SZ] = v;
        ref_mem[a % MEM_SZ]  = v;
    endtask

    // Issue one request on the SCLK_HALF=1 instance and collect what came back.
    task automatic run_txn(input logic mw, input logic [2:0] f3, input logic [23:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] dout,
                           output logic busy_ok, output logic ce_low_t1,
                           output logic [63:0] stream, output int nbits);
        int t0;
        si_log.delete();
        @(negedge clk);
        bus.ce = 1'b1; bus.memwrite = mw; bus.funct3 = f3; bus.addr = a; bus.datain = d;
        t0 = cyc;
        @(negedge clk);
        bus.ce = 1'b0;
        ce_low_t1 = (sram_ce === 1'b0);
        busy_ok = 1'b1;
        lat = -1;
        while (lat < 0) begin
            if (bus.valid === 1'b1) begin
                lat = cyc - t0;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                if (cyc - t0 > 3000) break;
                @(negedge clk);
            end
        end
        dout   = bus.dataout;
        nbits  = si_log.size();
        stream = '0;
        foreach (si_log[i]) stream = {stream[62:0], si_log[i]};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total += 7;
        if (sram_ce !== 1'b1)      begin bad++; $display("FAIL reset_sram_ce: got %b want 1", sram_ce); end
        if (sclk !== 1'b0)         begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        if (si !== 1'b0)           begin bad++; $display("FAIL reset_si: got %b want 0", si); end
        if (bus.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.valid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        if (bus.dataout !== 32'h0) begin bad++; $display("FAIL reset_dataout: got %h want 0", bus.dataout); end
        if (sram_ce2 !== 1'b1)     begin bad++; $display("FAIL reset_sram_ce2: got %b want 1", sram_ce2); end
        reset = 1'b0;
        exp_dout = '0;
    endtask

    task automatic test_lw();
        int lat, nb; logic [31:0] dout; logic bok, cel; logic [63:0] st;
        poke(24'h123, 8'h78); poke(24'h124, 8'h56); poke(24'h125, 8'h34); poke(24'h126, 8'h12);
        run_txn(1'b0, 3'b010, 24'h000123, 32'h0, lat, dout, bok, cel, st, nb);
        total += 6;
        if (lat !== 129)               begin bad++; $display("FAIL lw_latency: got %0d want 129", lat); end
        if (dout !== 32'h12345678)     begin bad++; $display("FAIL lw_data: got %h want 12345678", dout); end
        if (bok !== 1'b1)              begin bad++; $display("FAIL lw_busy: got %b want 1", bok); end
        if (cel !== 1'b1)              begin bad++; $display("FAIL lw_ce_fall_t1: got %b want 1", cel); end
        if (nb !== 64)                 begin bad++; $display("FAIL lw_bits: got %0d want 64", nb); end
        if ((st >> 32) !== 64'h03000123) begin bad++; $display("FAIL lw_stream: got %h want 03000123", st >> 32); end
        exp_dout = 32'h12345678;
    endtask

    task automatic test_lb_lbu();
        int lat, nb; logic [31:0] dout; logic bok, cel; logic [63:0] st;
        poke(24'h00000A, 8'h80);
        run_txn(1'b0, 3'b000, 24'h00000A, 32'h0, lat, dout, bok, cel, st, nb);
        total += 3;
        if (lat !== 81)            begin bad++; $display("FAIL lb_latency: got %0d want 81", lat); end
        if (dout !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", dout); end
        if (nb !== 40)             begin bad++; $display("FAIL lb_bits: got %0d want 40", nb); end
        run_txn(1'b0, 3'b100, 24'h00000A, 32'h0, lat, dout, bok, cel, st, nb);
        total += 2;
        if (lat !== 81)            begin bad++; $display("FAIL lbu_latency: got %0d want 81", lat); end
        if (dout !== 32'h00000080) begin bad++; $display("FAIL lbu_data: got %h want 00000080", dout); end
        exp_dout = 32'h00000080;
    endtask

    task automatic test_sh();
        int lat, nb; logic [31:0] dout; logic bok, cel; logic [63:0] st;
        run_txn(1'b1, 3'b001, 24'h01FFFE, 32'h1234ABCD, lat, dout, bok, cel, st, nb);
        ref_store(24'h01FFFE, 3'b001, 32'h1234ABCD);
        total += 4;
        if (lat !== 97)             begin bad++; $display("FAIL sh_latency: got %0d want 97", lat); end
        if (nb !== 48)              begin bad++; $display("FAIL sh_bits: got %0d want 48", nb); end
        if (st !== 64'h0201FFFECDAB) begin bad++; $display("FAIL sh_stream: got %h want 0201fffecdab", st); end
        if (dout !== exp_dout)      begin bad++; $display("FAIL sh_dataout_kept: got %h want %h", dout, exp_dout); end
        run_txn(1'b0, 3'b001, 24'h01FFFE, 32'h0, lat, dout, bok, cel, st, nb);
        total += 1;
        if (dout !== 32'hFFFFABCD)  begin bad++; $display("FAIL sh_readback_lh: got %h want ffffabcd", dout); end
        exp_dout = 32'hFFFFABCD;
    endtask

    task automatic test_reset_midway();
        int t0, lat, nb; logic [31:0] dout; logic bok, cel; logic [63:0] st;
        @(negedge clk);
        bus.ce = 1'b1; bus.memwrite = 1'b0; bus.funct3 = 3'b010; bus.addr = 24'h000123;
        t0 = cyc;
        @(negedge clk);
        bus.ce = 1'b0;
        while (cyc < t0 + 40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total += 5;
        if (sram_ce !== 1'b1)      begin bad++; $display("FAIL abort_sram_ce: got %b want 1", sram_ce); end
        if (sclk !== 1'b0)         begin bad++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        if (bus.busy !== 1'b0)     begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        if (bus.valid !== 1'b0)    begin bad++; $display("FAIL abort_valid: got %b want 0", bus.valid); end
        if (bus.dataout !== 32'h0) begin bad++; $display("FAIL abort_dataout: got %h want 0", bus.dataout); end
        exp_dout = '0;
        run_txn(1'b0, 3'b010, 24'h000123, 32'h0, lat, dout, bok, cel, st, nb);
        total += 2;
        if (lat !== 129)           begin bad++; $display("FAIL abort_relw_latency: got %0d want 129", lat); end
        if (dout !== 32'h12345678) begin bad++; $display("FAIL abort_relw_data: got %h want 12345678", dout); end
        exp_dout = 32'h12345678;
    endtask

    task automatic test_ce_ignore();
        int t0, v, lat, snap;
        snap = ce_falls;
        @(negedge clk);
        bus.ce = 1'b1; bus.memwrite = 1'b0; bus.funct3 = 3'b100; bus.addr = 24'h00000A;
        t0 = cyc;
        @(negedge clk);
        bus.ce = 1'b0;
        while (cyc < t0 + 5) @(negedge clk);
        bus.ce = 1'b1; bus.memwrite = 1'b1; bus.addr = 24'h000100;
        @(negedge clk);
        bus.ce = 1'b0; bus.memwrite = 1'b0; bus.addr = 24'h00000A;
        lat = -1;
        while (lat < 0) begin
            if (bus.valid === 1'b1) lat = cyc - t0;
            else begin
                if (cyc - t0 > 3000) break;
                @(negedge clk);
            end
        end
        total += 2;
        if (lat !== 81)               begin bad++; $display("FAIL busy_ce_latency: got %0d want 81", lat); end
        if (bus.dataout !== 32'h80)   begin bad++; $display("FAIL busy_ce_data: got %h want 00000080", bus.dataout); end
        // ce presented in the valid cycle and held one more cycle
        bus.ce = 1'b1; bus.funct3 = 3'b000;
        v = cyc;
        @(negedge clk);
        total += 1;
        if (sram_ce !== 1'b1) begin bad++; $display("FAIL done_ce_ignored: sram_ce got %b want 1", sram_ce); end
        @(negedge clk);
        bus.ce = 1'b0;
        total += 1;
        if (sram_ce !== 1'b0) begin bad++; $display("FAIL accept_after_valid: sram_ce got %b want 0", sram_ce); end
        lat = -1;
        while (lat < 0) begin
            if (bus.valid === 1'b1) lat = cyc - (v + 1);
            else begin
                if (cyc - v > 3000) break;
                @(negedge clk);
            end
        end
        total += 3;
        if (lat !== 81)                   begin bad++; $display("FAIL retry_latency: got %0d want 81", lat); end
        if (bus.dataout !== 32'hFFFFFF80) begin bad++; $display("FAIL retry_data: got %h want ffffff80", bus.dataout); end
        if (ce_falls - snap !== 2)        begin bad++; $display("FAIL ce_fall_count: got %0d want 2", ce_falls - snap); end
        exp_dout = 32'hFFFFFF80;
    endtask

    task automatic test_random();
        int lat, nb, n; logic [31:0] dout, d, exp_d; logic bok, cel, mw; logic [63:0] st, es;
        logic [23:0] a; logic [2:0] f3;
        for (int it = 0; it < 40; it++) begin
            mw = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 24'($urandom);
            d  = $urandom;
            n  = nbytes(f3);
            exp_d = mw ? exp_dout : ref_load(a, f3);
            es = exp_stream(mw, a, d, n);
            run_txn(mw, f3, a, d, lat, dout, bok, cel, st, nb);
            if (!mw) st = st >> (8 * n);
            total += 5;
            if (lat !== exp_lat(1, f3)) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, lat, exp_lat(1, f3)); end
            if (dout !== exp_d)         begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", it, dout, exp_d); end
            if (bok !== 1'b1)           begin bad++; $display("FAIL rnd_busy[%0d]: got %b want 1", it, bok); end
            if (nb !== 32 + 8 * n)      begin bad++; $display("FAIL rnd_bits[%0d]: got %0d want %0d", it, nb, 32 + 8 * n); end
            if (st !== es)              begin bad++; $display("FAIL rnd_stream[%0d]: got %h want %h", it, st, es); end
            if (mw) ref_store(a, f3, d);
            else    exp_dout = exp_d;
        end
    endtask

    task automatic test_sclk_half2();
        int t0, lat, bad_per; logic [31:0] d; logic [23:0] a; logic [63:0] st, es;
        d = $urandom;
        a = 24'($urandom);
        rise2.delete();
        si2_log.delete();
        @(negedge clk);
        bus2.ce = 1'b1; bus2.memwrite = 1'b1; bus2.funct3 = 3'b010; bus2.addr = a; bus2.datain = d;
        t0 = cyc;
        @(negedge clk);
        bus2.ce = 1'b0;
        lat = -1;
        while (lat < 0) begin
            if (bus2.valid === 1'b1) lat = cyc - t0;
            else begin
                if (cyc - t0 > 3000) break;
                @(negedge clk);
            end
        end
        bad_per = 0;
        for (int i = 1; i < rise2.size(); i++)
            if (rise2[i] - rise2[i-1] != 4) bad_per++;
        st = '0;
        foreach (si2_log[i]) st = {st[62:0], si2_log[i]};
        es = exp_stream(1'b1, a, d, 4);
        total += 5;
        if (lat !== 257)          begin bad++; $display("FAIL h2_latency: got %0d want 257", lat); end
        if (rise2.size() !== 64)  begin bad++; $display("FAIL h2_rises: got %0d want 64", rise2.size()); end
        if (bad_per !== 0)        begin bad++; $display("FAIL h2_period: got %0d bad periods want 0", bad_per); end
        if (rise2.size() > 0 && rise2[0] !== t0 + 3)
                                  begin bad++; $display("FAIL h2_first_rise: got %0d want %0d", rise2[0], t0 + 3); end
        if (st !== es)            begin bad++; $display("FAIL h2_stream: got %h want %h", st, es); end
    endtask

    task automatic test_protocol();
        total += 1;
        if (proto_err !== 0) begin bad++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        logic [7:0] b;
        reset = 1'b1;
        bus.ce = 1'b0;  bus.memwrite = 1'b0;  bus.funct3 = '0;  bus.addr = '0;  bus.datain = '0;
        bus2.ce = 1'b0; bus2.memwrite = 1'b0; bus2.funct3 = '0; bus2.addr = '0; bus2.datain = '0;
        for (int i = 0; i < MEM_SZ; i++) begin
            b = 8'($urandom);
            sram_mem[i] = b;
            ref_mem[i]  = b;
        end
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_reset_midway();
        test_ce_ignore();
        test_random();
        test_sclk_half2();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_spi_master.md
# sram_spi_master

Serial-SRAM bus master that sits directly downstream of the CPU's memory-phase and fetch requests. It converts one byte, halfword or word access into a single SPI mode-0 transaction on an external 23LC1024-class SRAM in sequential mode. Loads return little-endian, sign- or zero-extended data. Completion is reported with a busy/valid handshake.

## Interface
Parameters:
- SCLK_HALF, 1: clk cycles per sclk half-period (≥1).
- ADDR_W, 24: address bits shifted after the command byte.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  request strobe; sampled only while busy=0.
- memwrite  in  1  1 = store, 0 = load; sampled with ce.
- funct3  in  3  access type (RV32 load/store encoding); sampled with ce.
- addr  in  ADDR_W  byte address; sampled with ce.
- datain  in  32  store data; sampled with ce.
- dataout  out  32  load result; holds until the next load completes.
- busy  out  1  transaction in progress.
- valid  out  1  one-cycle completion pulse.
- si  out  1  SPI MOSI.
- so  in  1  SPI MISO.
- sclk  out  1  SPI clock; idle low.
- sram_ce  out  1  SRAM chip select, active low.

## Operation
- Reset values: dataout=0, busy=0, valid=0, si=0, sclk=0, sram_ce=1, FSM=IDLE. Reset in any state aborts immediately and releases the bus next cycle.
- Byte count N from funct3[1:0]:
  - 00 → 1
  - 01 → 2
  - 10 → 4
  - 11 → 4, treated as a word access.
- funct3[2]=1 selects zero-extension for loads. Stores ignore funct3[2].
- FSM states and transitions:
  - IDLE: ce=1 → latch memwrite/funct3/addr/datain, busy=1, go to SHIFT. Shift register = {cmd, addr}, cmd = 0x03 (read) or 0x02 (write). Bit count = 8+ADDR_W+8N.
  - SHIFT: sram_ce=0. Bits go MSB-first per byte, command then address.
  - SHIFT, write data: bytes go out as datain[7:0] first, then [15:8], and so on.
  - SHIFT, read data: bits are sampled on so and assembled LSB-byte-first, giving little-endian order.
  - SHIFT → DONE after the last falling sclk edge.
  - DONE: sram_ce=1, sclk=0. For loads, dataout ← extended result. valid=1 and busy=0 this cycle. Then go to IDLE.
- Load extension: N=1 extends bit 7, N=2 extends bit 15 (sign, or zero if funct3[2]=1). N=4 passes the word through.
- Stores leave dataout unchanged.
- ce while busy=1 is ignored; no queueing.
- A new ce in the DONE cycle is ignored. It is accepted earliest the cycle after valid.
- Address wraps inside the SRAM; the block performs no alignment or range check.

## Timing
- Each bit uses 2·SCLK_HALF clk cycles:
  - si updates while sclk is low, at the start of the bit.
  - sclk is high during the second half-period.
  - so is sampled on the clk edge where sclk rises.
- Let T0 be the cycle ce is accepted:
  - sram_ce falls at T0+1.
  - valid is asserted in cycle T0 + 1 + 2·SCLK_HALF·(8+ADDR_W+8N).
  - sram_ce is high in that same cycle.
- Worked latencies at defaults (T0 → valid):
  - LW/SW: 129 cycles.
  - LH/SH: 97 cycles.
  - LB/SB: 81 cycles.
- sram_ce stays high for at least 2 cycles between transactions: the DONE cycle plus the earliest IDLE accept cycle.
- sclk is never high while sram_ce=1.

## Test plan
- LW, addr=0x000123, SRAM model returns 0x78,0x56,0x34,0x12 → si stream 0x03,0x00,0x01,0x23. dataout=0x12345678 and valid pulse exactly at T0+129. busy high T0+1..T0+128.
- LB and LBU at 0x00000A, SRAM byte 0x80 → dataout 0xFFFFFF80 for LB, then 0x00000080 for LBU. Each completes at T0+81.
- SH datain=0x1234ABCD, addr=0x01FFFE → si stream 0x02,0x01,0xFF,0xFE,0xCD,0xAB (48 bits), valid at T0+97. dataout unchanged from the prior load.
- Reset asserted at T0+40 of an LW → next cycle sram_ce=1, sclk=0, busy=0, valid=0, dataout=0. A fresh LW afterwards completes normally.
- Second ce pulses at T0+5 and at the valid cycle → both ignored (no second sram_ce fall). A ce one cycle after valid is accepted.
- SCLK_HALF=2, SW → sclk period 4 cycles and valid at T0+257. Bench protocol checker confirms si is stable on every sclk rise.
